// File: rtl/debug_uart_tx_fifo.sv
// Debug UART transmitter with register interface, TX FIFO, programmable bit divider and TX-done irq.
// Optional: define DEBUG_UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module debug_uart_tx_fifo #(
  parameter int CLOCK_MHZ  = 14,
  parameter int BIT_RATE   = 1_000_000,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr_in,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        uart_txd,
  output logic        tx_busy,
  output logic        irq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [63:0] DIV_FULL = 64'(CLOCK_MHZ) * 64'd1_000_000 / 64'(BIT_RATE);
  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_FULL[DIV_WIDTH-1:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef DEBUG_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_eff;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, reload_q, reload_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           data_q, data_d;
  logic                 txd_q, txd_d;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     level_q;
  logic                 overflow_q, irq_en_q;
  logic                 wr_en, push_req, push, pop, empty, full;
  logic                 unused_bits;

  assign wr_en    = data_write_n != 2'b11;
  assign push_req = wr_en && (addr_in[3:2] == 2'd0);
  assign empty    = level_q == '0;
  assign full     = level_q == LVL_W'(FIFO_DEPTH);
  // A push into a full FIFO still fits when the transmitter pops on the same edge.
  assign push     = push_req && (!full || pop);
  assign div_eff  = (div_q == '0) ? DIV_WIDTH'(1) : div_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      div_q      <= DIV_RESET;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      level_q <= level_q + LVL_W'(1);
      else if (pop && !push) level_q <= level_q - LVL_W'(1);
      if (push_req && !push) overflow_q <= 1'b1;
      if (wr_en && (addr_in[3:2] == 2'd1)) begin
        if (data_in[2]) overflow_q <= 1'b0;
        irq_en_q <= data_in[3];
      end
      if (wr_en && (addr_in[3:2] == 2'd2)) div_q <= data_in[DIV_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      txd_q    <= 1'b1;
      cnt_q    <= '0;
      reload_q <= DIV_WIDTH'(1);
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      txd_q    <= txd_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      idx_q    <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    idx_d    = idx_q;
    data_d   = data_q;
    txd_d    = txd_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: pop = !empty;
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          txd_d   = data_q[0];
          idx_d   = '0;
          cnt_d   = reload_q - DIV_WIDTH'(1);
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = reload_q - DIV_WIDTH'(1);
          if (idx_q == 3'd7) begin
`ifdef DEBUG_UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = ^data_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = data_q[idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
`ifdef DEBUG_UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == '0) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
          cnt_d   = reload_q - DIV_WIDTH'(1);
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == '0) begin
          if (!empty) pop = 1'b1;
          else        state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Frame launch: the divider is sampled only here, so mid-frame writes wait for the next byte.
    if (pop) begin
      state_d  = S_START;
      txd_d    = 1'b0;
      data_d   = mem_q[rd_ptr_q];
      reload_d = div_eff;
      cnt_d    = div_eff - DIV_WIDTH'(1);
    end
  end

  assign uart_txd   = txd_q;
  assign tx_busy    = !empty || (state_q != S_IDLE);
  assign irq        = irq_en_q && !tx_busy;
  assign data_ready = 1'b1;

  always_comb begin
    data_out = '0;
    case (addr_in[3:2])
      2'd1: begin
        data_out[11:4] = 8'(level_q);
        data_out[3:0]  = {irq_en_q, overflow_q, empty, full};
`ifdef DEBUG_UART_TX_PARITY_EN
        data_out[12]   = 1'b1;
`endif
      end
      2'd2: data_out[DIV_WIDTH-1:0] = div_q;
      default: data_out = '0;
    endcase
  end

  assign unused_bits = ^{data_read_n, addr_in[1:0], data_in[31:8]};
endmodule

// File: tb/tb_debug_uart_tx_fifo.sv
// Bench for debug_uart_tx_fifo: directed scenarios plus a randomized run against a queue-based model.
module tb_debug_uart_tx_fifo;
  localparam int DEPTH   = 4;
  localparam int EXP_DIV = 14;
`ifdef DEBUG_UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] FEAT = 32'h0000_1000;
`else
  localparam int NB = 10;
  localparam logic [31:0] FEAT = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  addr_in;
  logic [31:0] data_in;
  logic [1:0]  data_write_n, data_read_n;
  logic [31:0] data_out;
  logic        data_ready, uart_txd, tx_busy, irq;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mon_d = EXP_DIV;
  int rx_byte[$];
  bit rx_ok[$];
  int rx_start[$];

  debug_uart_tx_fifo #(.CLOCK_MHZ(14), .BIT_RATE(1_000_000), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
    .data_ready(data_ready), .uart_txd(uart_txd), .tx_busy(tx_busy), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line receiver: samples every negedge, expects each slot to hold for mon_d clocks.
  always begin : rx_monitor
    int d, st;
    logic [10:0] bits;
    logic stable, aborted, ok;
    @(negedge clk);
    if (rst === 1'b0 && uart_txd === 1'b0) begin
      d = mon_d; st = cyc; bits = '0; stable = 1'b1; aborted = 1'b0;
      for (int slot = 0; slot < NB; slot++) begin
        for (int j = 0; j < d; j++) begin
          if (slot != 0 || j != 0) @(negedge clk);
          if (rst !== 1'b0) aborted = 1'b1;
          if (j == 0) bits[slot] = uart_txd;
          else if (uart_txd !== bits[slot]) stable = 1'b0;
        end
      end
      ok = stable && (bits[0] == 1'b0) && (bits[NB-1] == 1'b1);
`ifdef DEBUG_UART_TX_PARITY_EN
      ok = ok && (bits[9] == ^bits[8:1]);
`endif
      if (!aborted) begin
        rx_byte.push_back(int'(bits[8:1]));
        rx_ok.push_back(ok);
        rx_start.push_back(st);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    addr_in = a; data_in = d; data_write_n = 2'b00;
    @(posedge clk); #1;
    data_write_n = 2'b11;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    addr_in = a; data_read_n = 2'b00; #1;
    d = data_out; data_read_n = 2'b11;
  endtask

  task automatic clear_rx();
    rx_byte.delete(); rx_ok.delete(); rx_start.delete();
  endtask

  task automatic check_frames(input string nm, input int exp_b[$]);
    vectors++;
    if (rx_byte.size() != exp_b.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d frames, want %0d", nm, rx_byte.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < rx_byte.size(); i++) begin
      vectors++;
      if (rx_byte[i] != exp_b[i] || !rx_ok[i]) begin
        miscompares++;
        $display("FAIL %s_frame%0d: got %02h ok=%0d, want %02h ok=1", nm, i, rx_byte[i], rx_ok[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1; tick(3); rst = 1'b0;
    bus_rd(4'h8, rd); vectors++;
    if (rd !== 32'(EXP_DIV)) begin miscompares++; $display("FAIL rst_div: got %h want %h", rd, EXP_DIV); end
    bus_rd(4'h4, rd); vectors++;
    if (rd !== (FEAT | 32'h2)) begin miscompares++; $display("FAIL rst_status: got %h want %h", rd, FEAT | 32'h2); end
    vectors++;
    if ({uart_txd, tx_busy, irq, data_ready} !== 4'b1001) begin
      miscompares++; $display("FAIL rst_pins: got %b want 1001", {uart_txd, tx_busy, irq, data_ready});
    end
    bus_wr(4'hC, 32'hFFFF_FFFF);
    bus_rd(4'hC, rd); vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL rd_0c: got %h want 0", rd); end
    bus_rd(4'h0, rd); vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL rd_txdata: got %h want 0", rd); end
    bus_rd(4'h8, rd); vectors++;
    if (rd !== 32'(EXP_DIV)) begin miscompares++; $display("FAIL wr_0c_ignored: got %h want %h", rd, EXP_DIV); end
  endtask

  task automatic test_single_frame();
    int n;
    int exp_b[$];
    bus_wr(4'h8, 32'd4); mon_d = 4; clear_rx();
    bus_wr(4'h0, 32'hA5); n = cyc;
    vectors++;
    if (uart_txd !== 1'b1) begin miscompares++; $display("FAIL t2_txd_pre: got %b want 1", uart_txd); end
    tick(1); vectors++;
    if (uart_txd !== 1'b0) begin miscompares++; $display("FAIL t2_start_edge: got %b want 0", uart_txd); end
    tick(NB*4 - 1); vectors++;
    if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL t2_busy_last: got %b want 1", tx_busy); end
    tick(1); vectors++;
    if ({tx_busy, uart_txd} !== 2'b01) begin miscompares++; $display("FAIL t2_busy_drop: got %b want 01", {tx_busy, uart_txd}); end
    exp_b = '{32'hA5};
    check_frames("t2", exp_b);
    vectors++;
    if (rx_start.size() < 1 || rx_start[0] != n + 1) begin
      miscompares++; $display("FAIL t2_latency: got start %0d want %0d", (rx_start.size() > 0) ? rx_start[0] : -1, n + 1);
    end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] rd;
    int exp_b[$];
    bus_wr(4'h8, 32'd1); mon_d = 1; clear_rx();
    for (int i = 1; i <= 5; i++) bus_wr(4'h0, 32'(i));
    bus_rd(4'h4, rd); vectors++;
    if (rd !== (FEAT | 32'h41)) begin miscompares++; $display("FAIL t3_full_noovf: got %h want %h", rd, FEAT | 32'h41); end
    tick(70);
    exp_b = '{1, 2, 3, 4, 5};
    check_frames("t3a", exp_b);
    clear_rx();
    bus_wr(4'h0, 32'h10); tick(2);
    for (int i = 1; i <= 5; i++) bus_wr(4'h0, 32'h10 + 32'(i));
    bus_rd(4'h4, rd); vectors++;
    if (rd !== (FEAT | 32'h45)) begin miscompares++; $display("FAIL t3_overflow: got %h want %h", rd, FEAT | 32'h45); end
    bus_wr(4'h4, 32'h4);
    bus_rd(4'h4, rd); vectors++;
    if (rd !== (FEAT | 32'h41)) begin miscompares++; $display("FAIL t3_ovf_clear: got %h want %h", rd, FEAT | 32'h41); end
    tick(70);
    exp_b = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14};
    check_frames("t3b", exp_b);
  endtask

  task automatic test_back_to_back();
    int n;
    int exp_b[$];
    bus_wr(4'h8, 32'd2); mon_d = 2; clear_rx();
    bus_wr(4'h0, 32'h00); n = cyc;
    bus_wr(4'h0, 32'hFF);
    tick(NB*4 + 10);
    exp_b = '{32'h00, 32'hFF};
    check_frames("t4", exp_b);
    vectors++;
    if (rx_start.size() != 2 || rx_start[0] != n + 1 || rx_start[1] - rx_start[0] != NB*2) begin
      miscompares++;
      $display("FAIL t4_gap: got starts %0d,%0d want %0d,%0d", (rx_start.size() > 0) ? rx_start[0] : -1,
               (rx_start.size() > 1) ? rx_start[1] : -1, n + 1, n + 1 + NB*2);
    end
  endtask

  task automatic test_irq_divider();
    logic [31:0] rd;
    int exp_b[$];
    clear_rx();
    bus_wr(4'h4, 32'h8); vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL t5_irq_idle: got %b want 1", irq); end
    bus_wr(4'h0, 32'h3C); vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL t5_irq_queued: got %b want 0", irq); end
    tick(4);
    bus_wr(4'h8, 32'd8);
    bus_rd(4'h8, rd); vectors++;
    if (rd !== 32'd8) begin miscompares++; $display("FAIL t5_div_rd: got %h want 8", rd); end
    tick(NB*2 - 5); vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL t5_irq_last_stop: got %b want 0", irq); end
    tick(1); vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL t5_irq_rise: got %b want 1", irq); end
    mon_d = 8;
    bus_wr(4'h0, 32'hC3);
    tick(NB*8); vectors++;
    if ({irq, tx_busy} !== 2'b01) begin miscompares++; $display("FAIL t5_wide_busy: got %b want 01", {irq, tx_busy}); end
    tick(1); vectors++;
    if ({irq, tx_busy} !== 2'b10) begin miscompares++; $display("FAIL t5_wide_done: got %b want 10", {irq, tx_busy}); end
    exp_b = '{32'h3C, 32'hC3};
    check_frames("t5", exp_b);
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    bus_wr(4'h0, 32'h55); bus_wr(4'h0, 32'h66); bus_wr(4'h0, 32'h77); bus_wr(4'h0, 32'h88);
    tick(12);
    rst = 1'b1; tick(1); rst = 1'b0;
    clear_rx();
    vectors++;
    if ({uart_txd, tx_busy, irq} !== 3'b100) begin
      miscompares++; $display("FAIL t6_pins: got %b want 100", {uart_txd, tx_busy, irq});
    end
    bus_rd(4'h4, rd); vectors++;
    if (rd !== (FEAT | 32'h2)) begin miscompares++; $display("FAIL t6_status: got %h want %h", rd, FEAT | 32'h2); end
    bus_rd(4'h8, rd); vectors++;
    if (rd !== 32'(EXP_DIV)) begin miscompares++; $display("FAIL t6_div: got %h want %h", rd, EXP_DIV); end
    tick(300); vectors++;
    if (rx_byte.size() != 0 || uart_txd !== 1'b1) begin
      miscompares++; $display("FAIL t6_no_frames: got %0d frames txd=%b want 0 frames txd=1", rx_byte.size(), uart_txd);
    end
  endtask

  task automatic test_random();
    int mq[$];
    int exp_b[$];
    int exp_t[$];
    int d, fe, t;
    logic ovf, do_wr, pop;
    logic [7:0] b;
    logic [31:0] rd, ex;
    d = $urandom_range(1, 3);
    bus_wr(4'h8, 32'(d)); mon_d = d; clear_rx();
    fe = 0; ovf = 1'b0; t = cyc; b = '0;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 3);
      do_wr = (r == 0);
      if (do_wr) begin
        b = 8'($urandom);
        addr_in = 4'h0; data_in = {$urandom}; data_in[7:0] = b;
        data_write_n = 2'($urandom_range(0, 2));
      end else if (r == 1) begin
        ex = FEAT;
        ex[11:4] = 8'(mq.size());
        ex[2:0] = {ovf, mq.size() == 0, mq.size() == DEPTH};
        bus_rd(4'h4, rd); vectors++;
        if (rd !== ex) begin miscompares++; $display("FAIL rnd_status@%0d: got %h want %h", t, rd, ex); end
        vectors++;
        if (tx_busy !== (mq.size() > 0 || t < fe)) begin
          miscompares++; $display("FAIL rnd_busy@%0d: got %b want %b", t, tx_busy, (mq.size() > 0 || t < fe));
        end
      end
      @(posedge clk); #1;
      data_write_n = 2'b11;
      t = cyc;
      pop = (mq.size() > 0) && (t >= fe);
      if (pop) begin
        void'(mq.pop_front());
        fe = t + NB*d;
        exp_t.push_back(t);
      end
      if (do_wr) begin
        if (mq.size() < DEPTH) begin mq.push_back(int'(b)); exp_b.push_back(int'(b)); end
        else ovf = 1'b1;
      end
    end
    tick((DEPTH + 2) * NB * 3 + 20);
    check_frames("rnd", exp_b);
    for (int i = 0; i < exp_t.size() && i < rx_start.size(); i++) begin
      vectors++;
      if (rx_start[i] != exp_t[i]) begin
        miscompares++; $display("FAIL rnd_start%0d: got %0d want %0d", i, rx_start[i], exp_t[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; addr_in = '0; data_in = '0; data_write_n = 2'b11; data_read_n = 2'b11;
    test_reset();
    test_single_frame();
    test_fifo_overflow();
    test_back_to_back();
    test_irq_divider();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
